// File: rtl/guess_pkg.sv
// Shared definitions for the guess-LEDs game sequencer: state encoding,
// LFSR seed/taps, LED blink patterns and small arithmetic helpers.
package guess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_HIDE  = 3'd2,
    ST_GUESS = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  localparam logic [3:0] LFSR_SEED  = 4'b0001;
  localparam logic [3:0] LFSR_TAPS  = 4'b1100;

  localparam logic [3:0] PAT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_WIN    = 4'b1111;
  localparam logic [3:0] PAT_LOSE_A = 4'b0101;
  localparam logic [3:0] PAT_LOSE_B = 4'b1010;

  localparam logic [7:0] SCORE_MAX  = 8'd255;

  // One Fibonacci step for x^4+x^3+1: shift left, feed back parity of taps.
  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction

  // Streak increment that sticks at the maximum instead of wrapping.
  function automatic logic [7:0] score_inc(input logic [7:0] s);
    if (s == SCORE_MAX) begin
      return SCORE_MAX;
    end else begin
      return s + 8'd1;
    end
  endfunction

endpackage

// File: rtl/guess_ctrl_lfsr4.sv
// Free-running 4-bit maximal-length LFSR used as the secret source.
// Seeded non-zero, so the all-zero lock-up state is never visited.
module lfsr4
  import guess_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] Q
);

  logic [3:0] lfsr_r;

  // Advance the LFSR every clock; reset returns it to the seed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign Q = lfsr_r;

endmodule

// File: rtl/guess_ctrl.sv
// Round sequencer for the guess-LEDs game. Paced by the divider TICK:
// latch a random secret, show it, blank it, take a guess, flash result.
// Every output is a register loaded from the next-state decode, so each
// output reflects the new state in the same cycle the state changes.
module guess_ctrl
  import guess_pkg::*;
#(
  parameter int SHOW_TICKS   = 4,
  parameter int HIDE_TICKS   = 2,
  parameter int GUESS_TICKS  = 10,
  parameter int RESULT_TICKS = 6,
  parameter int CNT_W        = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       START,
  input  logic       CONFIRM,
  input  logic [3:0] BTN,
  output logic       DIV_RST,
  output logic [3:0] LED,
  output logic       WIN,
  output logic       LOSE,
  output logic [7:0] SCORE,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] HIDE_LOAD   = CNT_W'(HIDE_TICKS - 1);
  localparam logic [CNT_W-1:0] GUESS_LOAD  = CNT_W'(GUESS_TICKS - 1);
  localparam logic [CNT_W-1:0] RESULT_LOAD = CNT_W'(RESULT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       secret_r, secret_nxt_s;
  logic [7:0]       score_r, score_nxt_s;
  logic [3:0]       led_r, led_nxt_s;
  logic             div_rst_r, div_rst_nxt_s;
  logic             win_r, lose_r, busy_r;
  logic             start_prev_r, confirm_prev_r;
  logic             start_armed_r;
  logic [3:0]       lfsr_s;
  logic             start_edge_s, confirm_edge_s, expired_s;

  lfsr4 u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .Q   (lfsr_s)
  );

  // A START edge only counts once START has been seen low since reset,
  // so a level held through reset release cannot launch a round.
  assign start_edge_s   = START & ~start_prev_r & start_armed_r;
  assign confirm_edge_s = CONFIRM & ~confirm_prev_r;
  assign expired_s      = TICK && (cnt_r == CNT_ZERO);

  // Sample START/CONFIRM for rising-edge detection and arm START.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      start_prev_r   <= 1'b0;
      confirm_prev_r <= 1'b0;
      start_armed_r  <= 1'b0;
    end else begin
      start_prev_r   <= START;
      confirm_prev_r <= CONFIRM;
      start_armed_r  <= start_armed_r | ~START;
    end
  end

  // State, counter, secret, streak and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      secret_r  <= 4'b0000;
      score_r   <= 8'd0;
      led_r     <= PAT_OFF;
      div_rst_r <= 1'b1;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      secret_r  <= secret_nxt_s;
      score_r   <= score_nxt_s;
      led_r     <= led_nxt_s;
      div_rst_r <= div_rst_nxt_s;
      win_r     <= (state_nxt_s == ST_WIN);
      lose_r    <= (state_nxt_s == ST_LOSE);
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state decode: tick countdown, transitions and next LED value.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    secret_nxt_s  = secret_r;
    score_nxt_s   = score_r;
    led_nxt_s     = led_r;
    div_rst_nxt_s = 1'b1;

    case (state_r)
      ST_IDLE: begin
        led_nxt_s = PAT_OFF;
        if (start_edge_s) begin
          state_nxt_s   = ST_SHOW;
          secret_nxt_s  = lfsr_s;
          cnt_nxt_s     = SHOW_LOAD;
          div_rst_nxt_s = 1'b0;
          led_nxt_s     = lfsr_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SHOW: begin
        led_nxt_s = secret_r;
        if (expired_s) begin
          state_nxt_s = ST_HIDE;
          cnt_nxt_s   = HIDE_LOAD;
          led_nxt_s   = PAT_OFF;
        end else if (TICK) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      ST_HIDE: begin
        led_nxt_s = PAT_OFF;
        if (expired_s) begin
          state_nxt_s = ST_GUESS;
          cnt_nxt_s   = GUESS_LOAD;
          led_nxt_s   = BTN;
        end else if (TICK) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      ST_GUESS: begin
        led_nxt_s = BTN;
        // A commit beats a simultaneous timeout.
        if (confirm_edge_s) begin
          cnt_nxt_s = RESULT_LOAD;
          if (BTN == secret_r) begin
            state_nxt_s = ST_WIN;
            score_nxt_s = score_inc(score_r);
            led_nxt_s   = PAT_WIN;
          end else begin
            state_nxt_s = ST_LOSE;
            score_nxt_s = 8'd0;
            led_nxt_s   = PAT_LOSE_A;
          end
        end else if (expired_s) begin
          state_nxt_s = ST_LOSE;
          cnt_nxt_s   = RESULT_LOAD;
          score_nxt_s = 8'd0;
          led_nxt_s   = PAT_LOSE_A;
        end else if (TICK) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      ST_WIN: begin
        if (expired_s) begin
          state_nxt_s = ST_IDLE;
          led_nxt_s   = PAT_OFF;
        end else if (TICK) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
          led_nxt_s = (led_r == PAT_WIN) ? PAT_OFF : PAT_WIN;
        end else begin
          led_nxt_s = led_r;
        end
      end

      ST_LOSE: begin
        if (expired_s) begin
          state_nxt_s = ST_IDLE;
          led_nxt_s   = PAT_OFF;
        end else if (TICK) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
          led_nxt_s = (led_r == PAT_LOSE_A) ? PAT_LOSE_B : PAT_LOSE_A;
        end else begin
          led_nxt_s = led_r;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        led_nxt_s   = PAT_OFF;
      end
    endcase
  end

  assign DIV_RST = div_rst_r;
  assign LED     = led_r;
  assign WIN     = win_r;
  assign LOSE    = lose_r;
  assign SCORE   = score_r;
  assign BUSY    = busy_r;

endmodule

// File: tb/tb_guess_ctrl.sv
// Self-checking bench for guess_ctrl: randomized tick spacing, button
// values and guess outcomes, checked against a round-level model.
module tb_guess_ctrl;

  localparam int SHOW   = 4;
  localparam int HIDE   = 2;
  localparam int GUESS  = 10;
  localparam int RESULT = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic       CONFIRM = 1'b0;
  logic [3:0] BTN = 4'd0;
  logic       DIV_RST;
  logic [3:0] LED;
  logic       WIN;
  logic       LOSE;
  logic [7:0] SCORE;
  logic       BUSY;

  guess_ctrl #(
    .SHOW_TICKS(SHOW), .HIDE_TICKS(HIDE), .GUESS_TICKS(GUESS),
    .RESULT_TICKS(RESULT), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .CONFIRM(CONFIRM),
    .BTN(BTN), .DIV_RST(DIV_RST), .LED(LED), .WIN(WIN), .LOSE(LOSE),
    .SCORE(SCORE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc;
  int         m_score = 0;
  logic [3:0] m_secret;
  logic [3:0] seq [15];

  // Clock edges since reset release; indexes the expected LFSR sequence.
  always @(posedge CLK or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cyc();
    @(posedge CLK); #1;
  endtask

  task automatic tick_cyc();
    TICK = 1'b1;
    @(posedge CLK); #1;
    TICK = 1'b0;
  endtask

  // mode 0: correct guess, 1: wrong guess, 2: timeout,
  // 3: correct CONFIRM coinciding with the final guess tick.
  task automatic play_round(input int mode, input bit abort);
    int k;
    bit win;
    logic [3:0] exp_led;
    m_secret = seq[cyc % 15];
    START = 1'b1;
    idle_cyc();
    chk("div_rst_low", DIV_RST, 1'b0);
    chk("busy_start", BUSY, 1'b1);
    chk("show_entry", LED, m_secret);
    START = 1'b0;
    idle_cyc();
    chk("div_rst_high", DIV_RST, 1'b1);
    for (int i = 1; i <= SHOW; i++) begin
      repeat ($urandom_range(0, 2)) begin
        START = ($urandom_range(0, 1) == 1);
        idle_cyc();
        chk("show_hold", LED, m_secret);
      end
      tick_cyc();
      chk("show_tick", LED, (i < SHOW) ? m_secret : 4'b0000);
      chk("show_busy", BUSY, 1'b1);
    end
    START = 1'b0;
    for (int i = 1; i <= HIDE; i++) begin
      repeat ($urandom_range(0, 2)) begin
        CONFIRM = ($urandom_range(0, 1) == 1);
        idle_cyc();
        chk("hide_hold", LED, 4'b0000);
      end
      if (i == HIDE) begin
        CONFIRM = 1'b0;
        BTN = 4'($urandom_range(0, 15));
      end
      tick_cyc();
      chk("hide_tick", LED, (i < HIDE) ? 4'b0000 : BTN);
      chk("hide_win", WIN, 1'b0);
    end
    if (abort) begin
      #3 RST = 1'b0;
      #1;
      chk("rst_led", LED, 4'b0000);
      chk("rst_divrst", DIV_RST, 1'b1);
      chk("rst_win", WIN, 1'b0);
      chk("rst_lose", LOSE, 1'b0);
      chk("rst_score", SCORE, 8'd0);
      chk("rst_busy", BUSY, 1'b0);
      m_score = 0;
      return;
    end
    k = (mode == 2) ? GUESS : (mode == 3) ? GUESS - 1 : $urandom_range(0, GUESS - 1);
    for (int i = 1; i <= k; i++) begin
      repeat ($urandom_range(0, 2)) begin
        BTN = 4'($urandom_range(0, 15));
        idle_cyc();
        chk("guess_echo", LED, BTN);
      end
      tick_cyc();
      if (!(mode == 2 && i == GUESS)) begin
        chk("guess_lose", LOSE, 1'b0);
        chk("guess_led", LED, BTN);
      end
    end
    if (mode != 2) begin
      BTN = (mode == 1) ? (m_secret ^ 4'b0001) : m_secret;
      CONFIRM = 1'b1;
      TICK = (mode == 3);
      idle_cyc();
      TICK = 1'b0;
      CONFIRM = 1'b0;
    end
    win = (mode == 0 || mode == 3);
    m_score = win ? ((m_score >= 255) ? 255 : m_score + 1) : 0;
    exp_led = win ? 4'b1111 : 4'b0101;
    chk("res_win", WIN, win);
    chk("res_lose", LOSE, !win);
    chk("res_score", SCORE, m_score);
    chk("res_entry", LED, exp_led);
    for (int j = 1; j <= RESULT; j++) begin
      repeat ($urandom_range(0, 2)) begin
        idle_cyc();
        chk("res_hold", LED, exp_led);
      end
      tick_cyc();
      if (j < RESULT) begin
        exp_led = ~exp_led;
        chk("res_blink", LED, exp_led);
        chk("res_flag", win ? WIN : LOSE, 1'b1);
      end else begin
        chk("idle_led", LED, 4'b0000);
        chk("idle_win", WIN, 1'b0);
        chk("idle_lose", LOSE, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        chk("idle_score", SCORE, m_score);
      end
    end
  endtask

  initial begin
    seq[0] = 4'b0001;
    for (int i = 1; i < 15; i++)
      seq[i] = {seq[i-1][2:0], seq[i-1][3] ^ seq[i-1][2]};

    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_led", LED, 4'b0000);
    chk("reset_divrst", DIV_RST, 1'b1);
    chk("reset_score", SCORE, 8'd0);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_win", WIN, 1'b0);
    chk("reset_lose", LOSE, 1'b0);
    RST = 1'b1;
    repeat (3) idle_cyc();
    tick_cyc();
    chk("idle_tick_busy", BUSY, 1'b0);

    play_round(0, 1'b0);
    play_round(1, 1'b0);
    play_round(2, 1'b0);
    play_round(3, 1'b0);
    for (int r = 0; r < 256; r++) begin
      play_round(0, 1'b0);
      repeat ($urandom_range(0, 3)) idle_cyc();
    end
    chk("score_sat", SCORE, 8'd255);
    for (int r = 0; r < 6; r++) play_round(int'($urandom_range(0, 3)), 1'b0);

    play_round(0, 1'b1);
    START = 1'b1;
    idle_cyc();
    RST = 1'b1;
    repeat (5) idle_cyc();
    chk("held_start_busy", BUSY, 1'b0);
    chk("held_start_led", LED, 4'b0000);
    START = 1'b0;
    idle_cyc();
    play_round(0, 1'b0);
    chk("after_reset_score", SCORE, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/guess_ctrl.md
Name: guess_ctrl

Overview:
- Game sequencer for the guess-LEDs design, driven by the 1-cycle TICK pulse from the clock divider.
- Runs the round flow: latch a pseudo-random 4-bit secret, show it, blank it, accept a button guess, then flash a win/lose result.
- Restarts the divider phase at round start through DIV_RST.
- Keeps a saturating win streak.

Parameters:
- SHOW_TICKS, 4, ticks the secret is displayed (≥1)
- HIDE_TICKS, 2, ticks of blank display before guessing (≥1)
- GUESS_TICKS, 10, ticks allowed for a guess before timeout (≥1)
- RESULT_TICKS, 6, ticks of result blinking (≥1)
- CNT_W, 8, width of the tick down-counter; every *_TICKS value must be ≤ 2^CNT_W

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-low reset
- TICK  input  1  one-cycle pulse from divider
- START  input  1  start request, level; rising edge used
- CONFIRM  input  1  guess commit, level; rising edge used
- BTN  input  4  guess switches, debounced level
- DIV_RST  output  1  active-low divider restart, registered
- LED  output  4  LED drive, registered
- WIN  output  1  high throughout WIN state
- LOSE  output  1  high throughout LOSE state
- SCORE  output  8  consecutive-win streak
- BUSY  output  1  high in any state except IDLE

Behaviour:
- Reset (RST low, async): state=IDLE, LED=0, DIV_RST=1, WIN=0, LOSE=0, SCORE=0, counter=0, secret=0, LFSR=4'b0001, edge-detect registers=0.
- LFSR:
  - 4-bit Fibonacci, x^4+x^3+1, advances every clock in all states.
  - Never reaches 0; period 15.
- Edge detection: START and CONFIRM are sampled into one register each. An edge is current=1 and previous=0.
- IDLE: LED=0. START edge latches secret ← current LFSR, loads cnt ← SHOW_TICKS-1, pulses DIV_RST low for exactly the next cycle, and moves to SHOW. TICK is ignored.
- Common tick rule (SHOW/HIDE/GUESS/WIN/LOSE): on TICK with cnt≠0, cnt ← cnt-1. On TICK with cnt==0, the state transitions. Without TICK, cnt holds.
- SHOW: LED=secret. Expiry → HIDE, cnt ← HIDE_TICKS-1.
- HIDE: LED=0. Expiry → GUESS, cnt ← GUESS_TICKS-1.
- GUESS: LED=BTN (registered echo, 1-cycle latency).
  - CONFIRM edge with BTN==secret → WIN, SCORE ← SCORE+1 saturating at 255.
  - CONFIRM edge with BTN≠secret → LOSE, SCORE ← 0.
  - Timeout (expiry) → LOSE, SCORE ← 0.
  - CONFIRM edge and expiry in the same cycle: CONFIRM wins (compare is used, no timeout).
  - Every exit loads cnt ← RESULT_TICKS-1.
- WIN:
  - LED=4'b1111 on entry; toggles to 4'b0000 and back on every TICK.
  - WIN=1.
  - Expiry → IDLE.
- LOSE:
  - LED=4'b0101 on entry; alternates with 4'b1010 on every TICK.
  - LOSE=1.
  - Expiry → IDLE.
- Ignored edges:
  - START edges outside IDLE are ignored; no restart.
  - CONFIRM edges outside GUESS are ignored.
- Return to IDLE: LED=0, WIN=LOSE=0, SCORE retained.
- Latency:
  - State change is registered, one clock after the qualifying TICK or edge.
  - Outputs reflect the new state in that same cycle; all outputs are registered.
- Reset mid-round: immediate async return to reset values, including SCORE=0.
- Held level: a START held high across the return to IDLE does not restart; a new rising edge is required.

Decomposition:
- Package guess_pkg:
  - State encoding constants (IDLE=0, SHOW=1, HIDE=2, GUESS=3, WIN=4, LOSE=5; 3-bit).
  - LFSR seed 4'b0001 and tap mask 4'b1100.
  - Blink patterns 4'b1111/4'b0101/4'b1010.
- Sub-module lfsr4:
  - Ports CLK, RST (async active-low), Q[3:0].
  - Free-running; instantiated once.
- Remaining FSM, counter and edge detection stay in guess_ctrl.

Test Plan:
- Reset then START edge: DIV_RST low exactly 1 cycle, BUSY=1, LED=latched secret (nonzero) for 4 TICKs, then LED=0 for 2 TICKs, then GUESS.
- In GUESS, BTN=secret, CONFIRM edge: WIN=1, SCORE 0→1, LED 1111/0000 toggling for 6 TICKs, then IDLE with LED=0 and SCORE=1.
- In GUESS, BTN=secret^4'b0001, CONFIRM edge: LOSE=1, SCORE→0, LED 0101/1010 alternating, then IDLE after 6 TICKs.
- No CONFIRM in GUESS: after 10 TICKs, LOSE. Then repeat with a CONFIRM edge in the same cycle as the 10th TICK and BTN=secret: WIN, not LOSE.
- START toggled during SHOW and CONFIRM toggled during HIDE: no effect, and the round timing is unchanged. Run 256 consecutive wins: SCORE saturates at 255.
- RST low asynchronously mid-GUESS (between clock edges): all outputs take reset values immediately. START held high through release produces no round until a fresh rising edge.
